// File: rtl/uart_trig_pkg.sv
// Shared constants, clamp helpers and receiver state encoding for the UART pattern trigger.
package uart_trig_pkg;

    localparam logic [5:0]  ADDR_CFG   = 6'd48;
    localparam logic [5:0]  ADDR_PAT   = 6'd49;
    localparam logic [5:0]  ADDR_MASK  = 6'd50;
    localparam logic [5:0]  ADDR_STAT  = 6'd51;

    localparam logic [15:0] CFG_DIV_LO = 16'd0;
    localparam logic [15:0] CFG_DIV_HI = 16'd1;
    localparam logic [15:0] CFG_LEN    = 16'd2;
    localparam logic [15:0] CFG_CTRL   = 16'd3;

    localparam logic [15:0] RESET_DIV  = 16'd868;
    localparam logic [15:0] MIN_DIV    = 16'd4;
    localparam logic [3:0]  MAX_LEN    = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    function automatic logic [3:0] clamp_len(input logic [7:0] l);
        if (l == 8'd0)
            return 4'd1;
        if (l > 8'd8)
            return MAX_LEN;
        return l[3:0];
    endfunction

endpackage

// File: rtl/uart_trig_rx.sv
// 8N1 receiver: 2-FF synchroniser, optional inversion, mid-bit sampling with a down-counter.
// state | meaning
// IDLE  | waiting for a low level (and, after a framing error, for the line to go high first)
// START | counting half a bit, then confirming the start bit is still low
// DATA  | sampling 8 data bits LSB first, one per divider period
// STOP  | sampling the stop bit; high delivers the byte, low flags a framing error
module uart_trig_rx
    import uart_trig_pkg::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic        rx_i,
    input  logic        enable,
    input  logic        invert,
    input  logic [15:0] div,
    output logic [7:0]  rx_byte,
    output logic        byte_valid,
    output logic        frame_err
);

    logic        sync1, sync2, rx_s;
    rx_state_t   state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] div_lat, div_lat_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        wait_high, wait_high_n;
    logic        byte_valid_n, frame_err_n;
    logic        expire;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
        end
    end

    assign rx_s   = sync2 ^ invert;
    assign expire = (cnt == 16'd0);

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            cnt        <= '0;
            div_lat    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            wait_high  <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            div_lat    <= div_lat_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            wait_high  <= wait_high_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        div_lat_n    = div_lat;
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        wait_high_n  = wait_high;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (state)
            IDLE: begin
                if (wait_high && rx_s)
                    wait_high_n = 1'b0;
                if (!wait_high && !rx_s) begin
                    state_n   = START;
                    div_lat_n = div;
                    cnt_n     = (div >> 1) - 16'd1;
                end
            end
            START: begin
                if (expire) begin
                    if (!rx_s) begin
                        state_n   = DATA;
                        cnt_n     = div_lat - 16'd1;
                        bit_idx_n = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = div_lat - 16'd1;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (expire) begin
                    state_n = IDLE;
                    if (rx_s) begin
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                        wait_high_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Disable wins over everything, including a byte in flight.
        if (!enable) begin
            state_n      = IDLE;
            cnt_n        = '0;
            wait_high_n  = 1'b0;
            byte_valid_n = 1'b0;
            frame_err_n  = 1'b0;
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/reg_uart_trigger.sv
// Register-bus slave: UART byte history compared against a masked pattern, stretched trigger out.
module reg_uart_trigger
    import uart_trig_pkg::*;
#(
    parameter int TRIG_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [5:0]  reg_address,
    input  logic [15:0] reg_bytecnt,
    input  logic [7:0]  reg_datai,
    output logic [7:0]  reg_datao,
    input  logic [15:0] reg_size,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic        reg_addrvalid,
    input  logic [5:0]  reg_hypaddress,
    output logic [15:0] reg_hyplen,
    input  logic        rx_i,
    output logic        trigger_o
);

    logic [15:0]     cfg_div;
    logic [7:0]      cfg_len, cfg_ctrl;
    logic [7:0][7:0] pat, mask, hist, hist_new;
    logic [3:0]      fill, fill_new, len_eff;
    logic [15:0]     div_eff;
    logic [7:0]      match_cnt, ferr_cnt, hold_cnt;
    logic [7:0]      rx_byte;
    logic            byte_valid, frame_err, match_new;
    logic            enable, invert, wr_en, stat_clr;
    logic            unused_size;

    assign unused_size = ^reg_size;
    assign enable      = cfg_ctrl[0];
    assign invert      = cfg_ctrl[1];
    assign div_eff     = clamp_div(cfg_div);
    assign len_eff     = clamp_len(cfg_len);
    assign wr_en       = reg_write & reg_addrvalid;
    assign stat_clr    = wr_en && (reg_address == ADDR_STAT);

    uart_trig_rx u_rx (
        .clk        (clk),
        .reset_i    (reset_i),
        .rx_i       (rx_i),
        .enable     (enable),
        .invert     (invert),
        .div        (div_eff),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cfg_div  <= RESET_DIV;
            cfg_len  <= '0;
            cfg_ctrl <= '0;
            pat      <= '0;
            mask     <= '0;
        end else if (wr_en) begin
            case (reg_address)
                ADDR_CFG: begin
                    case (reg_bytecnt)
                        CFG_DIV_LO: cfg_div[7:0]  <= reg_datai;
                        CFG_DIV_HI: cfg_div[15:8] <= reg_datai;
                        CFG_LEN:    cfg_len       <= reg_datai;
                        CFG_CTRL:   cfg_ctrl      <= reg_datai;
                        default: ;
                    endcase
                end
                ADDR_PAT:  if (reg_bytecnt < 16'd8) pat[reg_bytecnt[2:0]]  <= reg_datai;
                ADDR_MASK: if (reg_bytecnt < 16'd8) mask[reg_bytecnt[2:0]] <= reg_datai;
                default: ;
            endcase
        end
    end

    // Compare against the history as it will look after this byte shifts in,
    // so the match registers in the same cycle the history updates.
    always_comb begin
        hist_new  = {hist[6:0], rx_byte};
        fill_new  = (fill == MAX_LEN) ? fill : fill + 4'd1;
        match_new = (fill_new >= len_eff);
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) < len_eff) && (((hist_new[i] ^ pat[i]) & mask[i]) != 8'd0))
                match_new = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            hist      <= '0;
            fill      <= '0;
            hold_cnt  <= '0;
            match_cnt <= '0;
            ferr_cnt  <= '0;
        end else begin
            if (hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;
            if (!enable) begin
                hist <= '0;
                fill <= '0;
            end else if (byte_valid) begin
                hist <= hist_new;
                fill <= fill_new;
                if (match_new) begin
                    hold_cnt <= 8'(TRIG_HOLD);
                    if (match_cnt != 8'hFF)
                        match_cnt <= match_cnt + 8'd1;
                end
            end
            if (frame_err && (ferr_cnt != 8'hFF))
                ferr_cnt <= ferr_cnt + 8'd1;
            if (stat_clr) begin
                match_cnt <= '0;
                ferr_cnt  <= '0;
            end
        end
    end

    assign trigger_o = (hold_cnt != 8'd0);

    always_comb begin
        reg_datao = '0;
        if (reg_addrvalid && reg_read) begin
            case (reg_address)
                ADDR_CFG: begin
                    case (reg_bytecnt)
                        CFG_DIV_LO: reg_datao = cfg_div[7:0];
                        CFG_DIV_HI: reg_datao = cfg_div[15:8];
                        CFG_LEN:    reg_datao = cfg_len;
                        CFG_CTRL:   reg_datao = cfg_ctrl;
                        default: ;
                    endcase
                end
                ADDR_PAT:  if (reg_bytecnt < 16'd8) reg_datao = pat[reg_bytecnt[2:0]];
                ADDR_MASK: if (reg_bytecnt < 16'd8) reg_datao = mask[reg_bytecnt[2:0]];
                ADDR_STAT: begin
                    if (reg_bytecnt == 16'd0)
                        reg_datao = match_cnt;
                    else if (reg_bytecnt == 16'd1)
                        reg_datao = ferr_cnt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_hyplen = '0;
        case (reg_hypaddress)
            ADDR_CFG:  reg_hyplen = 16'd4;
            ADDR_PAT:  reg_hyplen = 16'd8;
            ADDR_MASK: reg_hyplen = 16'd8;
            ADDR_STAT: reg_hyplen = 16'd2;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_uart_trigger.sv
// Bench for reg_uart_trigger: drives 8N1 frames, scoreboards expected trigger pulses per byte.
`timescale 1ns/1ps
module tb_reg_uart_trigger;

    localparam logic [5:0] A_CFG  = 6'd48;
    localparam logic [5:0] A_PAT  = 6'd49;
    localparam logic [5:0] A_MASK = 6'd50;
    localparam logic [5:0] A_STAT = 6'd51;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [5:0]  reg_address = '0;
    logic [15:0] reg_bytecnt = '0;
    logic [7:0]  reg_datai = '0;
    logic [7:0]  reg_datao;
    logic [15:0] reg_size = 16'd1;
    logic        reg_read = 1'b0;
    logic        reg_write = 1'b0;
    logic        reg_addrvalid = 1'b0;
    logic [5:0]  reg_hypaddress = 6'd52;
    logic [15:0] reg_hyplen;
    logic        rx_i = 1'b1;
    logic        trigger_o;

    reg_uart_trigger #(.TRIG_HOLD(8)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .reg_address    (reg_address),
        .reg_bytecnt    (reg_bytecnt),
        .reg_datai      (reg_datai),
        .reg_datao      (reg_datao),
        .reg_size       (reg_size),
        .reg_read       (reg_read),
        .reg_write      (reg_write),
        .reg_addrvalid  (reg_addrvalid),
        .reg_hypaddress (reg_hypaddress),
        .reg_hyplen     (reg_hyplen),
        .rx_i           (rx_i),
        .trigger_o      (trigger_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rises = 0, rise_cyc = 0, cur_w = 0, last_w = 0;
    logic trig_prev = 1'b0;
    always @(negedge clk) begin
        if (trigger_o && !trig_prev) begin
            rises    = rises + 1;
            rise_cyc = cyc;
        end
        if (trigger_o) begin
            cur_w = cur_w + 1;
        end else if (trig_prev) begin
            last_w = cur_w;
            cur_w  = 0;
        end
        trig_prev = trigger_o;
    end

    logic idle_lvl  = 1'b1;
    int   bit_div   = 8;
    int   start_cyc = 0;

    task automatic reg_wr(input logic [5:0] a, input int bc, input logic [7:0] d);
        @(posedge clk); #1;
        reg_address = a; reg_bytecnt = 16'(bc); reg_datai = d;
        reg_write = 1'b1; reg_addrvalid = 1'b1;
        @(posedge clk); #1;
        reg_write = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic reg_rd(input logic [5:0] a, input int bc, output logic [7:0] d);
        @(posedge clk); #1;
        reg_address = a; reg_bytecnt = 16'(bc);
        reg_read = 1'b1; reg_addrvalid = 1'b1;
        #2 d = reg_datao;
        #1 reg_read = 1'b0; reg_addrvalid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input int bc, input logic [7:0] exp);
        logic [7:0] d;
        reg_rd(a, bc, d);
        check_eq(tag, d, exp);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_lvl);
        logic [9:0] bits;
        bits = {stop_lvl, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rx_i = bits[i] ^ ~idle_lvl;
            if (i == 0) start_cyc = cyc;
            repeat (bit_div - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        rx_i = idle_lvl;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input int exp);
        int r0;
        r0 = rises;
        exp_q.push_back(exp);
        drive_frame(b, stop_lvl);
        repeat (bit_div + 20) @(posedge clk);
        check_eq($sformatf("trig_count_%02h", b), 32'(rises - r0), 32'(exp_q.pop_front()));
    endtask

    task automatic check_timing(input string tag);
        int d, nom;
        d   = rise_cyc - start_cyc;
        nom = (19 * bit_div) / 2 + 4;
        check_eq({tag, "_delay_in_window"}, 32'((d >= nom - 2) && (d <= nom + 2)), 32'd1);
        check_eq({tag, "_width"}, 32'(last_w), 32'd8);
    endtask

    initial begin
        bit done;
        #1;
        check_eq("rst_datao", reg_datao, 0);
        check_eq("rst_hyplen", reg_hyplen, 0);
        check_eq("rst_trigger", trigger_o, 0);
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        rd_chk("rst_div_lo", A_CFG, 0, 8'h64);
        rd_chk("rst_div_hi", A_CFG, 1, 8'h03);
        rd_chk("rst_stat0", A_STAT, 0, 8'h00);

        // single byte match
        reg_wr(A_CFG, 0, 8'd8);
        reg_wr(A_CFG, 1, 8'd0);
        reg_wr(A_CFG, 2, 8'd1);
        reg_wr(A_PAT, 0, 8'h55);
        reg_wr(A_MASK, 0, 8'hFF);
        reg_wr(A_CFG, 3, 8'h01);
        repeat (4) @(posedge clk);
        send_byte(8'h55, 1'b1, 1);
        check_timing("b55");
        rd_chk("stat_match_1", A_STAT, 0, 8'd1);

        // three-byte pattern, byte 0 newest
        reg_wr(A_CFG, 2, 8'd3);
        reg_wr(A_PAT, 0, 8'h01);
        reg_wr(A_PAT, 1, 8'h02);
        reg_wr(A_PAT, 2, 8'h03);
        reg_wr(A_MASK, 1, 8'hFF);
        reg_wr(A_MASK, 2, 8'hFF);
        send_byte(8'h03, 1'b1, 0);
        send_byte(8'h02, 1'b1, 0);
        send_byte(8'h01, 1'b1, 1);
        send_byte(8'h03, 1'b1, 0);
        send_byte(8'h02, 1'b1, 0);
        send_byte(8'h04, 1'b1, 0);
        rd_chk("stat_match_2", A_STAT, 0, 8'd2);

        // framing error then recovery
        reg_wr(A_CFG, 2, 8'd1);
        reg_wr(A_PAT, 0, 8'h55);
        send_byte(8'hA5, 1'b0, 0);
        rd_chk("stat_ferr_1", A_STAT, 1, 8'd1);
        send_byte(8'h55, 1'b1, 1);
        rd_chk("stat_match_3", A_STAT, 0, 8'd3);
        reg_wr(A_STAT, 0, 8'h00);
        rd_chk("stat_clr_match", A_STAT, 0, 8'd0);
        rd_chk("stat_clr_ferr", A_STAT, 1, 8'd0);

        // short start glitch
        begin
            int r0;
            r0 = rises;
            exp_q.push_back(0);
            @(posedge clk); #1 rx_i = 1'b0;
            repeat (bit_div / 4) @(posedge clk);
            #1 rx_i = 1'b1;
            repeat (40) @(posedge clk);
            check_eq("glitch_trig", 32'(rises - r0), 32'(exp_q.pop_front()));
        end
        rd_chk("glitch_ferr", A_STAT, 1, 8'd0);
        send_byte(8'h55, 1'b1, 1);

        // partial mask
        reg_wr(A_MASK, 0, 8'h0F);
        reg_wr(A_PAT, 0, 8'h05);
        send_byte(8'hF5, 1'b1, 1);
        send_byte(8'hF6, 1'b1, 0);

        // inverted line
        reg_wr(A_MASK, 0, 8'hFF);
        reg_wr(A_PAT, 0, 8'h55);
        reg_wr(A_CFG, 3, 8'h00);
        idle_lvl = 1'b0; rx_i = 1'b0;
        repeat (4) @(posedge clk);
        reg_wr(A_CFG, 3, 8'h03);
        repeat (4) @(posedge clk);
        send_byte(8'h55, 1'b1, 1);
        send_byte(8'h54, 1'b1, 0);
        reg_wr(A_CFG, 3, 8'h00);
        idle_lvl = 1'b1; rx_i = 1'b1;
        repeat (4) @(posedge clk);
        reg_wr(A_CFG, 3, 8'h01);
        repeat (4) @(posedge clk);

        // readback and divider clamp
        rd_chk("cfg_rd0", A_CFG, 0, 8'd8);
        rd_chk("cfg_rd1", A_CFG, 1, 8'd0);
        rd_chk("cfg_rd2", A_CFG, 2, 8'd1);
        rd_chk("cfg_rd3", A_CFG, 3, 8'h01);
        rd_chk("cfg_rd_oob", A_CFG, 4, 8'd0);
        reg_wr(A_CFG, 0, 8'd2);
        rd_chk("cfg_div2", A_CFG, 0, 8'd2);
        bit_div = 4;
        send_byte(8'h55, 1'b1, 1);
        check_timing("clamp");
        reg_hypaddress = A_PAT;  #1 check_eq("hyplen_pat", reg_hyplen, 16'd8);
        reg_hypaddress = A_CFG;  #1 check_eq("hyplen_cfg", reg_hyplen, 16'd4);
        reg_hypaddress = A_STAT; #1 check_eq("hyplen_stat", reg_hyplen, 16'd2);
        reg_hypaddress = 6'd52;  #1 check_eq("hyplen_52", reg_hyplen, 16'd0);

        // reset while trigger high and next byte in flight
        drive_frame(8'h55, 1'b1);
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (trigger_o) done = 1'b1;
        end
        check_eq("trig_before_reset", done, 1);
        rx_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_i = 1'b1;
        #1;
        check_eq("reset_trigger", trigger_o, 0);
        check_eq("reset_datao", reg_datao, 0);
        check_eq("reset_hyplen", reg_hyplen, 0);
        rx_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        rd_chk("reset_div_lo", A_CFG, 0, 8'h64);
        rd_chk("reset_div_hi", A_CFG, 1, 8'h03);
        rd_chk("reset_ctrl", A_CFG, 3, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
